// File: rtl/caliptra_fpga_axil_regfile.sv
// AXI4-Lite slave register file for the Caliptra FPGA sync/control path.
// Has independent AW/W holding buffers, byte strobes, read-only status registers and write-commit pulses.
module caliptra_fpga_axil_regfile #(
  parameter int unsigned         DATA_W    = 64,
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                         aclk,
  input  logic                         rstn,
  input  logic                         arvalid,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [2:0]                   arprot,
  output logic                         arready,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  input  logic                         awvalid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [2:0]                   awprot,
  output logic                         awready,
  input  logic                         wvalid,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic                         wready,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [1:0]                   bresp,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_in,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned HI_LSB = OFF + IDX_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  en_q;
  logic                  aw_full_q;
  logic [ADDR_W-1:0]     aw_addr_q;
  logic                  w_full_q;
  logic [DATA_W-1:0]     w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [1:0]            rresp_q;
  logic [NUM_REGS-1:0]   pulse_q;
  logic [NUM_REGS-1:0]   pulse_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     reg_in_arr [NUM_REGS];

  logic                  commit_c;
  logic                  aw_hs_c;
  logic                  w_hs_c;
  logic                  ar_hs_c;
  logic [IDX_W-1:0]      wr_idx_c;
  logic                  wr_in_range_c;
  logic                  wr_en_c;
  logic [DATA_W-1:0]     wmask_c;
  logic [DATA_W-1:0]     wr_data_d;
  logic [IDX_W-1:0]      rd_idx_c;
  logic                  rd_in_range_c;
  logic [DATA_W-1:0]     rd_data_d;
  logic                  unused_prot;

  assign unused_prot = ^{arprot, awprot};

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> HI_LSB) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF +: IDX_W];
  endfunction

  // Flat bus views of the register array
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_out[g*DATA_W +: DATA_W] = regs_q[g];
    assign reg_in_arr[g]               = reg_in[g*DATA_W +: DATA_W];
  end

  // A commit frees both buffers, so a new AW/W can be accepted in the same cycle
  assign commit_c = aw_full_q & w_full_q & (~bvalid_q | bready);
  assign awready  = en_q & (~aw_full_q | commit_c);
  assign wready   = en_q & (~w_full_q | commit_c);
  assign arready  = en_q & (~rvalid_q | rready);
  assign aw_hs_c  = awvalid & awready;
  assign w_hs_c   = wvalid & wready;
  assign ar_hs_c  = arvalid & arready;

  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign bvalid       = bvalid_q;
  assign bresp        = bresp_q;
  assign reg_wr_pulse = pulse_q;

  // Write decode and byte-merge of the committed transaction
  always_comb begin
    wmask_c       = '0;
    pulse_d       = '0;
    wr_idx_c      = addr_idx(aw_addr_q);
    wr_in_range_c = addr_in_range(aw_addr_q);
    wr_en_c       = commit_c & wr_in_range_c & ~RO_MASK[wr_idx_c];
    for (int unsigned k = 0; k < STRB_W; k++) begin
      wmask_c[k*8 +: 8] = {8{w_strb_q[k]}};
    end
    wr_data_d = (regs_q[wr_idx_c] & ~wmask_c) | (w_data_q & wmask_c);
    if (wr_en_c && (|w_strb_q)) begin
      pulse_d[wr_idx_c] = 1'b1;
    end
  end

  // Read decode; RO registers mirror the fabric status inputs
  always_comb begin
    rd_idx_c      = addr_idx(araddr);
    rd_in_range_c = addr_in_range(araddr);
    rd_data_d     = '0;
    if (rd_in_range_c) begin
      rd_data_d = RO_MASK[rd_idx_c] ? reg_in_arr[rd_idx_c] : regs_q[rd_idx_c];
    end
  end

  // Channel readiness is held off until the first edge after reset release
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // AW and W one-entry holding buffers
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs_c) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= awaddr;
      end else if (commit_c) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs_c) begin
        w_full_q <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end else if (commit_c) begin
        w_full_q <= 1'b0;
      end
    end
  end

  // Write response channel
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit_c) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register storage and commit pulses
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_en_c && (wr_idx_c == IDX_W'(i))) begin
          regs_q[i] <= wr_data_d;
        end
      end
    end
  end

  // Read data channel; data and response hold until rready
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs_c) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_d;
      rresp_q  <= rd_in_range_c ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_axil_regfile.sv
// Directed bench for caliptra_fpga_axil_regfile: a 64-bit instance with one RO register and a 32-bit instance.
module tb_caliptra_fpga_axil_regfile;

  localparam logic [63:0] RV   = 64'hCAFE_0000_0000_BEEF;
  localparam logic [63:0] STAT = 64'hDEAD_BEEF_CAFE_F00D;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic          a_arvalid, a_arready, a_rvalid, a_rready;
  logic [31:0]   a_araddr, a_awaddr;
  logic [63:0]   a_rdata, a_wdata;
  logic [1:0]    a_rresp, a_bresp;
  logic          a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic [7:0]    a_wstrb;
  logic [1023:0] a_reg_out, a_reg_in;
  logic [15:0]   a_pulse;

  logic          b_arvalid, b_arready, b_rvalid, b_rready;
  logic [31:0]   b_araddr, b_awaddr;
  logic [31:0]   b_rdata, b_wdata;
  logic [1:0]    b_rresp, b_bresp;
  logic          b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic [3:0]    b_wstrb;
  logic [511:0]  b_reg_out, b_reg_in;
  logic [15:0]   b_pulse;

  caliptra_fpga_axil_regfile #(
    .DATA_W(64), .ADDR_W(32), .NUM_REGS(16), .RO_MASK(16'h0004), .RESET_VAL(RV)
  ) u_dut64 (
    .aclk(clk), .rstn(rstn),
    .arvalid(a_arvalid), .araddr(a_araddr), .arprot(3'b000), .arready(a_arready),
    .rvalid(a_rvalid), .rready(a_rready), .rdata(a_rdata), .rresp(a_rresp),
    .awvalid(a_awvalid), .awaddr(a_awaddr), .awprot(3'b000), .awready(a_awready),
    .wvalid(a_wvalid), .wdata(a_wdata), .wstrb(a_wstrb), .wready(a_wready),
    .bvalid(a_bvalid), .bready(a_bready), .bresp(a_bresp),
    .reg_out(a_reg_out), .reg_in(a_reg_in), .reg_wr_pulse(a_pulse)
  );

  caliptra_fpga_axil_regfile #(
    .DATA_W(32), .ADDR_W(32), .NUM_REGS(16), .RO_MASK(16'h0000), .RESET_VAL(32'h0)
  ) u_dut32 (
    .aclk(clk), .rstn(rstn),
    .arvalid(b_arvalid), .araddr(b_araddr), .arprot(3'b000), .arready(b_arready),
    .rvalid(b_rvalid), .rready(b_rready), .rdata(b_rdata), .rresp(b_rresp),
    .awvalid(b_awvalid), .awaddr(b_awaddr), .awprot(3'b000), .awready(b_awready),
    .wvalid(b_wvalid), .wdata(b_wdata), .wstrb(b_wstrb), .wready(b_wready),
    .bvalid(b_bvalid), .bready(b_bready), .bresp(b_bresp),
    .reg_out(b_reg_out), .reg_in(b_reg_in), .reg_wr_pulse(b_pulse)
  );

  function automatic logic [63:0] a_reg(input int i);
    return a_reg_out[i*64 +: 64];
  endfunction

  function automatic logic [31:0] b_reg(input int i);
    return b_reg_out[i*32 +: 32];
  endfunction

  // AW and W together, then accept the response one cycle after it appears
  task automatic a_write(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] strb,
                         output logic bv, output logic [1:0] br, output logic [15:0] pl);
    @(negedge clk);
    a_awvalid = 1'b1; a_awaddr = addr; a_wvalid = 1'b1; a_wdata = data; a_wstrb = strb;
    @(negedge clk);
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    @(negedge clk);
    bv = a_bvalid; br = a_bresp; pl = a_pulse; a_bready = 1'b1;
    @(negedge clk);
    a_bready = 1'b0;
  endtask

  task automatic a_read(input logic [31:0] addr, output logic rv, output logic [63:0] rd,
                        output logic [1:0] rs);
    @(negedge clk);
    a_arvalid = 1'b1; a_araddr = addr;
    @(negedge clk);
    a_arvalid = 1'b0; rv = a_rvalid; rd = a_rdata; rs = a_rresp; a_rready = 1'b1;
    @(negedge clk);
    a_rready = 1'b0;
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] data,
                         output logic bv, output logic [1:0] br);
    @(negedge clk);
    b_awvalid = 1'b1; b_awaddr = addr; b_wvalid = 1'b1; b_wdata = data; b_wstrb = 4'hF;
    @(negedge clk);
    b_awvalid = 1'b0; b_wvalid = 1'b0;
    @(negedge clk);
    bv = b_bvalid; br = b_bresp; b_bready = 1'b1;
    @(negedge clk);
    b_bready = 1'b0;
  endtask

  task automatic b_read(input logic [31:0] addr, output logic rv, output logic [31:0] rd);
    @(negedge clk);
    b_arvalid = 1'b1; b_araddr = addr;
    @(negedge clk);
    b_arvalid = 1'b0; rv = b_rvalid; rd = b_rdata; b_rready = 1'b1;
    @(negedge clk);
    b_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic rv; logic [63:0] rd; logic [1:0] rs;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_arready, a_awready, a_wready, b_arready} !== 4'b0000) begin
      failures++; $display("FAIL reset_ready: got %b want 0000", {a_arready, a_awready, a_wready, b_arready});
    end
    checks++;
    if ({a_bvalid, a_rvalid, a_rdata, a_pulse} !== '0) begin
      failures++; $display("FAIL reset_outputs: bvalid=%b rvalid=%b rdata=%h pulse=%h want all 0",
                           a_bvalid, a_rvalid, a_rdata, a_pulse);
    end
    checks++;
    if (a_reg(0) !== RV || a_reg(15) !== RV) begin
      failures++; $display("FAIL reset_regs: got %h/%h want %h", a_reg(0), a_reg(15), RV);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_arready, a_awready, a_wready, b_awready} !== 4'b1111) begin
      failures++; $display("FAIL release_ready: got %b want 1111", {a_arready, a_awready, a_wready, b_awready});
    end
    a_read(32'h18, rv, rd, rs);
    checks++;
    if (rv !== 1'b1 || rd !== RV || rs !== 2'b00) begin
      failures++; $display("FAIL reset_read_reg3: rvalid=%b rdata=%h rresp=%b want 1 %h 00", rv, rd, rs, RV);
    end
  endtask

  task automatic test_strobe_w_first();
    logic bv; logic [1:0] br; logic [15:0] pl;
    @(negedge clk);
    a_wvalid = 1'b1; a_wdata = 64'h1122_3344_5566_7788; a_wstrb = 8'h0F;
    @(negedge clk);
    a_wvalid = 1'b0;
    checks++;
    if (a_wready !== 1'b0 || a_bvalid !== 1'b0) begin
      failures++; $display("FAIL w_buffer_full: wready=%b bvalid=%b want 0 0", a_wready, a_bvalid);
    end
    @(negedge clk);
    a_awvalid = 1'b1; a_awaddr = 32'h08;
    @(negedge clk);
    a_awvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_bvalid !== 1'b1 || a_bresp !== 2'b00 || a_pulse !== 16'h0002) begin
      failures++; $display("FAIL strobe_resp: bvalid=%b bresp=%b pulse=%h want 1 00 0002", a_bvalid, a_bresp, a_pulse);
    end
    checks++;
    if (a_reg(1) !== 64'hCAFE_0000_5566_7788) begin
      failures++; $display("FAIL strobe_data: got %h want cafe000055667788", a_reg(1));
    end
    a_bready = 1'b1;
    @(negedge clk);
    a_bready = 1'b0;
    checks++;
    if (a_bvalid !== 1'b0 || a_pulse !== 16'h0000) begin
      failures++; $display("FAIL strobe_pulse_end: bvalid=%b pulse=%h want 0 0000", a_bvalid, a_pulse);
    end
    a_write(32'h50, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, bv, br, pl);
    checks++;
    if (bv !== 1'b1 || br !== 2'b00 || pl !== 16'h0000 || a_reg(10) !== RV) begin
      failures++; $display("FAIL zero_strobe: bvalid=%b bresp=%b pulse=%h reg=%h want 1 00 0000 %h", bv, br, pl, a_reg(10), RV);
    end
  endtask

  task automatic test_out_of_range();
    logic bv; logic [1:0] br; logic [15:0] pl; logic rv; logic [63:0] rd; logic [1:0] rs;
    logic [1023:0] snap;
    snap = a_reg_out;
    a_write(32'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, bv, br, pl);
    checks++;
    if (bv !== 1'b1 || br !== 2'b10 || pl !== 16'h0000) begin
      failures++; $display("FAIL oor_write: bvalid=%b bresp=%b pulse=%h want 1 10 0000", bv, br, pl);
    end
    checks++;
    if (a_reg_out !== snap) begin
      failures++; $display("FAIL oor_no_update: reg0=%h want %h", a_reg(0), snap[63:0]);
    end
    a_read(32'h80, rv, rd, rs);
    checks++;
    if (rv !== 1'b1 || rd !== 64'h0 || rs !== 2'b10) begin
      failures++; $display("FAIL oor_read: rvalid=%b rdata=%h rresp=%b want 1 0 10", rv, rd, rs);
    end
  endtask

  task automatic test_ro();
    logic bv; logic [1:0] br; logic [15:0] pl; logic rv; logic [63:0] rd; logic [1:0] rs;
    a_write(32'h10, 64'h0123_4567_89AB_CDEF, 8'hFF, bv, br, pl);
    checks++;
    if (bv !== 1'b1 || br !== 2'b00 || pl !== 16'h0000) begin
      failures++; $display("FAIL ro_write: bvalid=%b bresp=%b pulse=%h want 1 00 0000", bv, br, pl);
    end
    a_read(32'h10, rv, rd, rs);
    checks++;
    if (rv !== 1'b1 || rd !== STAT || rs !== 2'b00) begin
      failures++; $display("FAIL ro_read: rvalid=%b rdata=%h rresp=%b want 1 %h 00", rv, rd, rs, STAT);
    end
  endtask

  task automatic test_backpressure();
    a_bready = 1'b0;
    @(negedge clk);
    a_awvalid = 1'b1; a_awaddr = 32'h20; a_wvalid = 1'b1; a_wdata = 64'h4444_0000_0000_0004; a_wstrb = 8'hFF;
    @(negedge clk);
    a_awaddr = 32'h28; a_wdata = 64'h5555_0000_0000_0005;
    @(negedge clk);
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    checks++;
    if (a_bvalid !== 1'b1 || a_pulse !== 16'h0010 || a_reg(4) !== 64'h4444_0000_0000_0004) begin
      failures++; $display("FAIL bp_first: bvalid=%b pulse=%h reg4=%h want 1 0010 4444000000000004", a_bvalid, a_pulse, a_reg(4));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_awready, a_wready, a_bvalid} !== 3'b001 || a_reg(5) !== RV) begin
        failures++; $display("FAIL bp_stall%0d: awready=%b wready=%b bvalid=%b reg5=%h want 0 0 1 %h",
                             i, a_awready, a_wready, a_bvalid, a_reg(5), RV);
      end
    end
    a_bready = 1'b1;
    @(negedge clk);
    checks++;
    if (a_bvalid !== 1'b1 || a_bresp !== 2'b00 || a_pulse !== 16'h0020 || a_reg(5) !== 64'h5555_0000_0000_0005) begin
      failures++; $display("FAIL bp_second: bvalid=%b bresp=%b pulse=%h reg5=%h want 1 00 0020 5555000000000005",
                           a_bvalid, a_bresp, a_pulse, a_reg(5));
    end
    @(negedge clk);
    a_bready = 1'b0;
    checks++;
    if (a_bvalid !== 1'b0) begin
      failures++; $display("FAIL bp_drain: bvalid=%b want 0", a_bvalid);
    end
  endtask

  task automatic test_back_to_back();
    a_bready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        checks++;
        if (a_pulse !== 16'h0040) begin
          failures++; $display("FAIL b2b_pulse6: got %h want 0040", a_pulse);
        end
      end
      a_awvalid = 1'b1; a_awaddr = 32'((6 + i) * 8);
      a_wvalid = 1'b1; a_wdata = 64'hB2B0_0000_0000_0000 + 64'(i); a_wstrb = 8'hFF;
      checks++;
      if ({a_awready, a_wready} !== 2'b11) begin
        failures++; $display("FAIL b2b_ready%0d: got %b want 11", i, {a_awready, a_wready});
      end
    end
    @(negedge clk);
    a_awvalid = 1'b0; a_wvalid = 1'b0;
    checks++;
    if (a_pulse !== 16'h0080) begin
      failures++; $display("FAIL b2b_pulse7: got %h want 0080", a_pulse);
    end
    @(negedge clk);
    checks++;
    if (a_pulse !== 16'h0100 || a_bvalid !== 1'b1) begin
      failures++; $display("FAIL b2b_pulse8: pulse=%h bvalid=%b want 0100 1", a_pulse, a_bvalid);
    end
    checks++;
    if (a_reg(6) !== 64'hB2B0_0000_0000_0000 || a_reg(7) !== 64'hB2B0_0000_0000_0001 ||
        a_reg(8) !== 64'hB2B0_0000_0000_0002) begin
      failures++; $display("FAIL b2b_data: got %h %h %h want b2b0..00 b2b0..01 b2b0..02", a_reg(6), a_reg(7), a_reg(8));
    end
    @(negedge clk);
    a_bready = 1'b0;
    checks++;
    if (a_bvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain: bvalid=%b want 0", a_bvalid);
    end
  endtask

  task automatic test_same_cycle_64();
    logic bv; logic [1:0] br; logic [15:0] pl; logic rv; logic [63:0] rd; logic [1:0] rs;
    a_write(32'h0, 64'h1, 8'hFF, bv, br, pl);
    @(negedge clk);
    a_awvalid = 1'b1; a_awaddr = 32'h0; a_wvalid = 1'b1; a_wdata = 64'h2; a_wstrb = 8'hFF;
    @(negedge clk);
    a_awvalid = 1'b0; a_wvalid = 1'b0; a_arvalid = 1'b1; a_araddr = 32'h0;
    @(negedge clk);
    a_arvalid = 1'b0;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 64'h1 || a_bvalid !== 1'b1 || a_reg(0) !== 64'h2) begin
      failures++; $display("FAIL same64: rvalid=%b rdata=%h bvalid=%b reg0=%h want 1 1 1 2", a_rvalid, a_rdata, a_bvalid, a_reg(0));
    end
    a_rready = 1'b1; a_bready = 1'b1;
    @(negedge clk);
    a_rready = 1'b0; a_bready = 1'b0;
    a_read(32'h0, rv, rd, rs);
    checks++;
    if (rv !== 1'b1 || rd !== 64'h2) begin
      failures++; $display("FAIL same64_after: rvalid=%b rdata=%h want 1 2", rv, rd);
    end
  endtask

  task automatic test_same_cycle_32();
    logic bv; logic [1:0] br; logic rv; logic [31:0] rd;
    b_write(32'h4, 32'h1, bv, br);
    checks++;
    if (bv !== 1'b1 || br !== 2'b00 || b_reg(1) !== 32'h1) begin
      failures++; $display("FAIL w32_write: bvalid=%b bresp=%b reg1=%h want 1 00 1", bv, br, b_reg(1));
    end
    @(negedge clk);
    b_awvalid = 1'b1; b_awaddr = 32'h4; b_wvalid = 1'b1; b_wdata = 32'h2; b_wstrb = 4'hF;
    @(negedge clk);
    b_awvalid = 1'b0; b_wvalid = 1'b0; b_arvalid = 1'b1; b_araddr = 32'h4;
    @(negedge clk);
    b_arvalid = 1'b0;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h1 || b_pulse !== 16'h0002) begin
      failures++; $display("FAIL same32: rvalid=%b rdata=%h pulse=%h want 1 1 0002", b_rvalid, b_rdata, b_pulse);
    end
    b_rready = 1'b1; b_bready = 1'b1;
    @(negedge clk);
    b_rready = 1'b0; b_bready = 1'b0;
    b_read(32'h4, rv, rd);
    checks++;
    if (rv !== 1'b1 || rd !== 32'h2) begin
      failures++; $display("FAIL same32_after: rvalid=%b rdata=%h want 1 2", rv, rd);
    end
  endtask

  task automatic test_mid_reset();
    logic rv; logic [63:0] rd; logic [1:0] rs;
    a_bready = 1'b0; a_rready = 1'b0;
    @(negedge clk);
    a_awvalid = 1'b1; a_awaddr = 32'h48; a_wvalid = 1'b1; a_wdata = 64'h9999_0000_0000_0009; a_wstrb = 8'hFF;
    a_arvalid = 1'b1; a_araddr = 32'h18;
    @(negedge clk);
    a_awvalid = 1'b0; a_wvalid = 1'b0; a_arvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (a_bvalid !== 1'b1 || a_rvalid !== 1'b1 || a_reg(9) !== 64'h9999_0000_0000_0009) begin
      failures++; $display("FAIL mid_pre: bvalid=%b rvalid=%b reg9=%h want 1 1 9999000000000009", a_bvalid, a_rvalid, a_reg(9));
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({a_bvalid, a_rvalid, a_arready, a_awready} !== 4'b0000 || a_reg(9) !== RV || a_reg(1) !== RV) begin
      failures++; $display("FAIL mid_reset: bvalid=%b rvalid=%b arready=%b awready=%b reg9=%h reg1=%h want 0 0 0 0 %h",
                           a_bvalid, a_rvalid, a_arready, a_awready, a_reg(9), a_reg(1), RV);
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_bvalid, a_rvalid, a_arready, a_awready, a_wready} !== 5'b00111) begin
      failures++; $display("FAIL mid_release: bvalid=%b rvalid=%b ready=%b want 0 0 111",
                           a_bvalid, a_rvalid, {a_arready, a_awready, a_wready});
    end
    a_read(32'h48, rv, rd, rs);
    checks++;
    if (rv !== 1'b1 || rd !== RV || rs !== 2'b00) begin
      failures++; $display("FAIL mid_read: rvalid=%b rdata=%h rresp=%b want 1 %h 00", rv, rd, rs, RV);
    end
  endtask

  initial begin
    a_arvalid = 1'b0; a_araddr = '0; a_rready = 1'b0;
    a_awvalid = 1'b0; a_awaddr = '0; a_wvalid = 1'b0; a_wdata = '0; a_wstrb = '0; a_bready = 1'b0;
    a_reg_in = '0;
    a_reg_in[2*64 +: 64] = STAT;
    a_reg_in[3*64 +: 64] = 64'h3333_3333_3333_3333;
    b_arvalid = 1'b0; b_araddr = '0; b_rready = 1'b0;
    b_awvalid = 1'b0; b_awaddr = '0; b_wvalid = 1'b0; b_wdata = '0; b_wstrb = '0; b_bready = 1'b0;
    b_reg_in = '0;

    test_reset();
    test_strobe_w_first();
    test_out_of_range();
    test_ro();
    test_backpressure();
    test_back_to_back();
    test_same_cycle_64();
    test_same_cycle_32();
    test_mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
